// File: rtl/apb_requester_bridge.sv
// apb_requester_bridge: turns a valid/ready command stream into APB4 transfers, one in flight,
// and returns each result on a valid/ready response channel. Define APB_REQ_TIMEOUT_EN to build the ACCESS watchdog.
module apb_requester_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  // command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  // response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  // APB requester side
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  // Clears the byte-lane offset so PADDR is always bus-width aligned.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ADDR_LSB;

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 32) begin : g_bad_addr_width
    $error("apb_requester_bridge: ADDR_WIDTH must be 1..32");
  end
  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_data_width
    $error("apb_requester_bridge: DATA_WIDTH must be 8, 16 or 32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_requester_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   cmd_fire;
  logic   rsp_fire;
  logic   xfer_done;
  logic   xfer_abort;
  logic   wd_expired;

  // A new command may only start once the response slot is free or is being drained this cycle.
  assign cmd_ready = (state_q == IDLE) && (!rsp_valid || rsp_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  // --------------------------------------------------------------------------
  // Optional ACCESS watchdog
  // --------------------------------------------------------------------------
`ifdef APB_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             rsp_err_q;

  assign wd_expired = (state_q == ACCESS) && (wd_cnt_q == CNT_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wd_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wd_cnt_q <= '0;
    end else if (state_q == ACCESS && !PREADY && !wd_expired) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_err_q <= 1'b0;
    end else if (xfer_done) begin
      rsp_err_q <= 1'b0;
    end else if (xfer_abort) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign wd_expired = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Transfer FSM
  // --------------------------------------------------------------------------
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation/synthesis mismatches.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over an expiring watchdog in the same cycle.
        if (PREADY) begin
          state_d   = IDLE;
          xfer_done = 1'b1;
        end else if (wd_expired) begin
          state_d    = IDLE;
          xfer_abort = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // APB output registers
  // --------------------------------------------------------------------------
  // PSEL/PENABLE are registered from the next state so they are glitch-free flop outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PSTRB   <= '0;
    end else begin
      PSEL    <= (state_d != IDLE);
      PENABLE <= (state_d == ACCESS);
      if (cmd_fire) begin
        PADDR  <= cmd_addr & ADDR_MASK;
        PWRITE <= cmd_write;
        PWDATA <= cmd_write ? cmd_wdata : '0;
        PSTRB  <= cmd_write ? cmd_strb : '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response register
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (xfer_done) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= PWRITE ? '0 : PRDATA;
    end else if (xfer_abort) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= '0;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_requester_bridge.sv
// Self-checking bench for apb_requester_bridge: per-cycle vector table plus hand-written
// back-to-back, reset-in-ACCESS and (with APB_REQ_TIMEOUT_EN) watchdog sequences.
module tb_apb_requester_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef APB_REQ_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 256;
`endif

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE, PREADY;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [SW-1:0] PSTRB;

  // Completer model: either a fixed table value or an address-derived echo.
  logic          echo;
  logic [DW-1:0] prdata_v;
  assign PRDATA = echo ? {16'hC0DE, PADDR[15:0]} : prdata_v;

  apb_requester_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One record per clock: inputs for the cycle, cmd_ready expected during it,
  // and registered outputs expected just after the closing edge.
  typedef struct {
    logic        cv, cw;
    logic [31:0] ca, cd;
    logic [3:0]  cs;
    logic        rr, pr;
    logic [31:0] prd;
    logic        x_cr, x_sel, x_en;
    logic [31:0] x_addr;
    logic        x_wr;
    logic [3:0]  x_strb;
    logic [31:0] x_wdata;
    logic        x_rv;
    logic [31:0] x_rdata;
    logic        x_err;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  // Issues one command and waits (bounded) for its response; lat counts edges from the handshake.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output int lat, output int acc, output logic [31:0] rd, output logic er,
                      output logic sel_at_rsp);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; rsp_ready = 1'b1;
    #1;
    check("xfer cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    lat = -1; acc = 0; rd = 'x; er = 1'bx; sel_at_rsp = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err; sel_at_rsp = PSEL;
        break;
      end
      if (PSEL && PENABLE) acc++;
      @(posedge PCLK); #1;
    end
  endtask

  int          lat, acc;
  logic [31:0] rd;
  logic        er, sel;
  int          rsp_cyc[$];
  logic [31:0] rsp_dat[$];
  int          cmd_idx;
  logic        fire;

  initial begin
    //          cv cw ca            cd            cs    rr pr prd           | cr sel en addr         wr strb  wdata         rv rdata         err
    vecs[0]  = '{1, 1, 32'h00001003, 32'hA5A50001, 4'hF, 1, 1, 32'h0,        1, 1, 0, 32'h00001000, 1, 4'hF, 32'hA5A50001, 0, 32'h0,        0};
    vecs[1]  = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 1, 32'h0,        0, 1, 1, 32'h00001000, 1, 4'hF, 32'hA5A50001, 0, 32'h0,        0};
    vecs[2]  = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 1, 32'h55555555, 0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'h0,        0};
    vecs[3]  = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 32'h0,        1, 0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 32'h0,        0};
    vecs[4]  = '{1, 0, 32'h00002000, 32'h12345678, 4'hF, 1, 0, 32'h0,        1, 1, 0, 32'h00002000, 0, 4'h0, 32'h0,        0, 32'h0,        0};
    vecs[5]  = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 1, 32'hFFFFFFFF, 0, 1, 1, 32'h00002000, 0, 4'h0, 32'h0,        0, 32'h0,        0};
    vecs[6]  = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 32'h0,        0, 1, 1, 32'h00002000, 0, 4'h0, 32'h0,        0, 32'h0,        0};
    vecs[7]  = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 32'h0,        0, 1, 1, 32'h00002000, 0, 4'h0, 32'h0,        0, 32'h0,        0};
    vecs[8]  = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 32'h0,        0, 1, 1, 32'h00002000, 0, 4'h0, 32'h0,        0, 32'h0,        0};
    vecs[9]  = '{0, 0, 32'h0,        32'h0,        4'h0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'hDEADBEEF, 0};
    vecs[10] = '{1, 0, 32'h00003004, 32'h0,        4'h0, 0, 1, 32'h0,        0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'hDEADBEEF, 0};
    vecs[11] = '{1, 0, 32'h00003004, 32'h0,        4'h0, 0, 1, 32'h0,        0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'hDEADBEEF, 0};
    vecs[12] = '{1, 0, 32'h00003004, 32'h0,        4'h0, 1, 0, 32'h0,        1, 1, 0, 32'h00003004, 0, 4'h0, 32'h0,        0, 32'h0,        0};
    vecs[13] = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 32'h0,        0, 1, 1, 32'h00003004, 0, 4'h0, 32'h0,        0, 32'h0,        0};
    vecs[14] = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 1, 32'h0BADF00D, 0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'h0BADF00D, 0};
    vecs[15] = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 32'h0,        1, 0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 32'h0,        0};
    vecs[16] = '{1, 1, 32'h00000042, 32'h11223344, 4'h6, 1, 0, 32'h0,        1, 1, 0, 32'h00000040, 1, 4'h6, 32'h11223344, 0, 32'h0,        0};
    vecs[17] = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 1, 32'h0,        0, 1, 1, 32'h00000040, 1, 4'h6, 32'h11223344, 0, 32'h0,        0};
    vecs[18] = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 32'hFFFFFFFF, 0, 1, 1, 32'h00000040, 1, 4'h6, 32'h11223344, 0, 32'h0,        0};
    vecs[19] = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'h0,        0};
    vecs[20] = '{0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'h0,        0};
    vecs[21] = '{0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 32'h0,        1, 0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 32'h0,        0};

    // Reset state
    PRESETn = 1'b0; echo = 1'b0; prdata_v = '0; PREADY = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
    #3;
    check("reset PSEL", {31'd0, PSEL}, 32'd0);
    check("reset PENABLE", {31'd0, PENABLE}, 32'd0);
    check("reset PWRITE", {31'd0, PWRITE}, 32'd0);
    check("reset PADDR", PADDR, 32'd0);
    check("reset PWDATA", PWDATA, 32'd0);
    check("reset PSTRB", {28'd0, PSTRB}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    #9 PRESETn = 1'b1;
    #1 check("post-reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge PCLK); #1;

    // Table: zero-wait write, 3-wait read, back-pressure, partial-strobe write
    for (int i = 0; i < NVEC; i++) begin
      cmd_valid = vecs[i].cv; cmd_write = vecs[i].cw; cmd_addr = vecs[i].ca;
      cmd_wdata = vecs[i].cd; cmd_strb = vecs[i].cs; rsp_ready = vecs[i].rr;
      PREADY = vecs[i].pr; prdata_v = vecs[i].prd;
      #1;
      check($sformatf("v%0d cmd_ready", i), {31'd0, cmd_ready}, {31'd0, vecs[i].x_cr});
      @(posedge PCLK); #1;
      check($sformatf("v%0d PSEL", i), {31'd0, PSEL}, {31'd0, vecs[i].x_sel});
      check($sformatf("v%0d PENABLE", i), {31'd0, PENABLE}, {31'd0, vecs[i].x_en});
      check($sformatf("v%0d rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].x_rv});
      if (vecs[i].x_sel) begin
        check($sformatf("v%0d PADDR", i), PADDR, vecs[i].x_addr);
        check($sformatf("v%0d PWRITE", i), {31'd0, PWRITE}, {31'd0, vecs[i].x_wr});
        check($sformatf("v%0d PSTRB", i), {28'd0, PSTRB}, {28'd0, vecs[i].x_strb});
        check($sformatf("v%0d PWDATA", i), PWDATA, vecs[i].x_wdata);
      end
      if (vecs[i].x_rv) begin
        check($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].x_rdata);
        check($sformatf("v%0d rsp_err", i), {31'd0, rsp_err}, {31'd0, vecs[i].x_err});
      end
    end

    // Back-to-back: 4 zero-wait reads, responses in order, 3 cycles apart
    echo = 1'b1; PREADY = 1'b1; rsp_ready = 1'b1;
    cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0; cmd_idx = 0;
    for (int cyc = 0; cyc < 40 && rsp_dat.size() < 4; cyc++) begin
      cmd_valid = (cmd_idx < 4);
      cmd_addr  = 32'h100 + 32'(4 * cmd_idx);
      #1;
      fire = cmd_valid && cmd_ready;
      @(posedge PCLK); #1;
      if (fire) cmd_idx++;
      if (rsp_valid) begin
        rsp_cyc.push_back(cyc);
        rsp_dat.push_back(rsp_rdata);
      end
    end
    cmd_valid = 1'b0;
    check("b2b response count", 32'(rsp_dat.size()), 32'd4);
    for (int i = 0; i < rsp_dat.size(); i++) begin
      check($sformatf("b2b rdata %0d", i), rsp_dat[i], 32'hC0DE0100 + 32'(4 * i));
      if (i > 0) check($sformatf("b2b spacing %0d", i), 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd3);
    end
    @(posedge PCLK); #1;

    // Reset asserted mid-wait in ACCESS
    echo = 1'b0; PREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_wdata = 32'h0F0F0F0F; cmd_strb = 4'hF;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check("rst mid ACCESS PENABLE", {31'd0, PENABLE}, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    check("rst async PSEL", {31'd0, PSEL}, 32'd0);
    check("rst async PENABLE", {31'd0, PENABLE}, 32'd0);
    check("rst async rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst async PADDR", PADDR, 32'd0);
    check("rst async PWRITE", {31'd0, PWRITE}, 32'd0);
    rsp_ready = 1'b0;
    #2 PRESETn = 1'b1;
    #1 check("rst release cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge PCLK); #1;
    echo = 1'b1; PREADY = 1'b1;
    xfer(1'b0, 32'h602, 32'h0, 4'hF, lat, acc, rd, er, sel);
    check("post-rst latency", 32'(lat), 32'd3);
    check("post-rst rdata", rd, 32'hC0DE0600);
    check("post-rst err", {31'd0, er}, 32'd0);
    @(posedge PCLK); #1;

`ifdef APB_REQ_TIMEOUT_EN
    // Watchdog: PREADY held low aborts after TIMEOUT_CYCLES ACCESS cycles
    echo = 1'b0; PREADY = 1'b0; prdata_v = 32'hBAD0BAD0;
    xfer(1'b0, 32'h700, 32'h0, 4'h0, lat, acc, rd, er, sel);
    check("wd latency", 32'(lat), 32'd6);
    check("wd access cycles", 32'(acc), 32'd4);
    check("wd PSEL dropped", {31'd0, sel}, 32'd0);
    check("wd rsp_err", {31'd0, er}, 32'd1);
    check("wd rsp_rdata", rd, 32'd0);
    @(posedge PCLK); #1;
    echo = 1'b1; PREADY = 1'b1;
    xfer(1'b0, 32'h704, 32'h0, 4'h0, lat, acc, rd, er, sel);
    check("wd follow-up latency", 32'(lat), 32'd3);
    check("wd follow-up err", {31'd0, er}, 32'd0);
    check("wd follow-up rdata", rd, 32'hC0DE0704);
    @(posedge PCLK); #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
